// File: rtl/etc_pkg.sv
// Shared types and constants for the etc job scheduler: job modes, etc opcodes,
// datapath latency and per-beat tracking record.
package etc_pkg;

    typedef enum logic [1:0] {
        MODE_W       = 2'd0,
        MODE_2W_A    = 2'd1,
        MODE_2W_B    = 2'd2,
        MODE_ILLEGAL = 2'd3
    } mode_e;

    localparam logic [3:0] ETC_OP_W    = 4'd0;
    localparam logic [3:0] ETC_OP_IDLE = 4'd1;
    localparam logic [3:0] ETC_OP_2W_A = 4'd2;
    localparam logic [3:0] ETC_OP_2W_B = 4'd3;

    localparam int unsigned ETC_LATENCY = 2;

    // Per-beat record carried alongside etc's pipeline.
    typedef struct packed {
        logic  valid;
        logic  beat;
        logic  last;
        mode_e mode;
    } beat_info_t;

    function automatic logic [1:0] beats_of(input mode_e m);
        case (m)
            MODE_W, MODE_2W_A: beats_of = 2'd1;
            MODE_2W_B:         beats_of = 2'd2;
            default:           beats_of = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] op_of(input mode_e m);
        case (m)
            MODE_W:    op_of = ETC_OP_W;
            MODE_2W_A: op_of = ETC_OP_2W_A;
            MODE_2W_B: op_of = ETC_OP_2W_B;
            default:   op_of = ETC_OP_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/etc_sync_fifo.sv
// Single-clock FIFO with registered occupancy count; full/empty derive from the
// count so they never depend on same-cycle push/pop.
module etc_sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/etc_sched.sv
// Job scheduler / front-end for the etc tensor-core datapath.
// Optional perf counters are built when ETC_SCHED_PERF_EN is defined.
module etc_sched
    import etc_pkg::*;
#(
    parameter int unsigned W         = 12,
    parameter int unsigned JOB_DEPTH = 4,
    parameter int unsigned RES_DEPTH = 4,
    parameter int unsigned TAG_W     = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [1:0]         job_mode,
    input  logic [TAG_W-1:0]   job_tag,
    input  logic [16*W-1:0]    job_a,
    input  logic [16*W-1:0]    job_b,
    output logic [3:0]         etc_op,
    output logic [16*W-1:0]    etc_in_a,
    output logic [16*W-1:0]    etc_in_b,
    input  logic [16*2*W-1:0]  etc_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [16*2*W-1:0]  res_data,
    output logic [TAG_W-1:0]   res_tag,
    output logic               res_beat,
    output logic               res_last,
    output logic               illegal_mode
`ifdef ETC_SCHED_PERF_EN
    ,
    output logic [31:0]        perf_busy_cyc,
    output logic [31:0]        perf_jobs,
    output logic [31:0]        perf_stall_cyc
`endif
);

    localparam int unsigned DW = 16*W;
    localparam int unsigned RW = 16*2*W;
    localparam int unsigned CW = $clog2(RES_DEPTH+1);

    typedef struct packed {
        mode_e            mode;
        logic [TAG_W-1:0] tag;
        logic [DW-1:0]    a;
        logic [DW-1:0]    b;
    } job_t;

    typedef struct packed {
        logic [RW-1:0]    data;
        logic [TAG_W-1:0] tag;
        logic             beat;
        logic             last;
    } res_t;

    typedef enum logic [1:0] {QUIET, RUN, OP3_HI} state_e;

    job_t   job_in;
    job_t   job_head;
    logic   job_full;
    logic   job_empty;
    logic   job_pop;

    res_t   res_in;
    res_t   res_head;
    logic   res_full;
    logic   res_empty;
    logic   res_push;
    logic   res_pop;

    state_e           state;
    logic             quiet_cnt;
    logic [CW-1:0]    credits;
    logic [CW-1:0]    credits_nxt;
    logic [1:0]       head_beats;
    logic             can_issue;
    beat_info_t       cur_info;
    logic [TAG_W-1:0] cur_tag;
    beat_info_t       pipe_info [ETC_LATENCY];
    logic [TAG_W-1:0] pipe_tag  [ETC_LATENCY];

    assign job_in = '{mode: mode_e'(job_mode), tag: job_tag, a: job_a, b: job_b};
    assign job_ready = !job_full;

    etc_sync_fifo #(
        .WIDTH ($bits(job_t)),
        .DEPTH (JOB_DEPTH)
    ) u_job_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (job_valid && job_ready),
        .wdata (job_in),
        .pop   (job_pop),
        .rdata (job_head),
        .full  (job_full),
        .empty (job_empty)
    );

    // Illegal jobs have zero beats, so they always pass the credit check.
    assign head_beats  = beats_of(job_head.mode);
    assign can_issue   = (state == RUN) && !job_empty && (credits >= CW'(head_beats));
    assign job_pop     = can_issue;
    assign res_pop     = res_valid && res_ready;
    assign res_push    = pipe_info[ETC_LATENCY-1].valid;
    assign credits_nxt = credits - (can_issue ? CW'(head_beats) : '0) + CW'(res_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= QUIET;
            quiet_cnt    <= 1'b0;
            etc_op       <= ETC_OP_IDLE;
            etc_in_a     <= '0;
            etc_in_b     <= '0;
            illegal_mode <= 1'b0;
            credits      <= CW'(RES_DEPTH);
            cur_info     <= '0;
            cur_tag      <= '0;
            for (int unsigned i = 0; i < ETC_LATENCY; i++) begin
                pipe_info[i] <= '0;
                pipe_tag[i]  <= '0;
            end
        end else begin
            illegal_mode <= 1'b0;
            credits      <= credits_nxt;
            pipe_info[0] <= cur_info;
            pipe_tag[0]  <= cur_tag;
            for (int unsigned i = 1; i < ETC_LATENCY; i++) begin
                pipe_info[i] <= pipe_info[i-1];
                pipe_tag[i]  <= pipe_tag[i-1];
            end

            case (state)
                QUIET: begin
                    etc_op         <= ETC_OP_IDLE;
                    cur_info.valid <= 1'b0;
                    quiet_cnt      <= 1'b1;
                    if (quiet_cnt) begin
                        quiet_cnt <= 1'b0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (can_issue && job_head.mode == MODE_ILLEGAL) begin
                        illegal_mode <= 1'b1;
                        etc_op       <= ETC_OP_IDLE;
                        cur_info     <= '0;
                    end else if (can_issue) begin
                        etc_op   <= op_of(job_head.mode);
                        etc_in_a <= job_head.a;
                        etc_in_b <= job_head.b;
                        cur_tag  <= job_head.tag;
                        cur_info <= '{valid: 1'b1, beat: 1'b0,
                                      last: (job_head.mode != MODE_2W_B),
                                      mode: job_head.mode};
                        if (job_head.mode == MODE_2W_B) state <= OP3_HI;
                    end else begin
                        etc_op         <= ETC_OP_IDLE;
                        cur_info.valid <= 1'b0;
                    end
                end
                OP3_HI: begin
                    // etc_op and operands hold; only the beat record advances.
                    cur_info <= '{valid: 1'b1, beat: 1'b1, last: 1'b1, mode: MODE_2W_B};
                    state    <= RUN;
                end
                default: state <= QUIET;
            endcase
        end
    end

    always_comb begin
        res_in      = '0;
        res_in.data = etc_out;
        if (pipe_info[ETC_LATENCY-1].mode == MODE_2W_A) res_in.data[RW-1:RW/2] = '0;
        res_in.tag  = pipe_tag[ETC_LATENCY-1];
        res_in.beat = pipe_info[ETC_LATENCY-1].beat;
        res_in.last = pipe_info[ETC_LATENCY-1].last;
    end

    etc_sync_fifo #(
        .WIDTH ($bits(res_t)),
        .DEPTH (RES_DEPTH)
    ) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (res_push),
        .wdata (res_in),
        .pop   (res_pop),
        .rdata (res_head),
        .full  (res_full),
        .empty (res_empty)
    );

    assign res_valid = !res_empty;
    assign res_data  = res_head.data;
    assign res_tag   = res_head.tag;
    assign res_beat  = res_head.beat;
    assign res_last  = res_head.last;

    // Credits guarantee space; a push into a full result FIFO means the accounting broke.
    always_ff @(posedge clk) begin
        if (rst_n && res_push) assert (!res_full) else $error("etc_sched: result FIFO overflow");
    end

`ifdef ETC_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_cyc  <= '0;
            perf_jobs      <= '0;
            perf_stall_cyc <= '0;
        end else begin
            if (etc_op != ETC_OP_IDLE && !(&perf_busy_cyc))
                perf_busy_cyc <= perf_busy_cyc + 32'd1;
            if (can_issue && job_head.mode != MODE_ILLEGAL && !(&perf_jobs))
                perf_jobs <= perf_jobs + 32'd1;
            if (state == RUN && !job_empty && !can_issue && !(&perf_stall_cyc))
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
        end
    end
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_etc_sched.sv
// Directed bench for etc_sched with a behavioural etc stand-in and a result scoreboard.
module tb_etc_sched;

    localparam int unsigned W     = 12;
    localparam int unsigned TAG_W = 4;
    localparam int unsigned DW    = 16*W;
    localparam int unsigned RW    = 16*2*W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              job_valid = 1'b0;
    logic              job_ready;
    logic [1:0]        job_mode = '0;
    logic [TAG_W-1:0]  job_tag = '0;
    logic [DW-1:0]     job_a = '0;
    logic [DW-1:0]     job_b = '0;
    logic [3:0]        etc_op;
    logic [DW-1:0]     etc_in_a;
    logic [DW-1:0]     etc_in_b;
    logic [RW-1:0]     etc_out = '0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [RW-1:0]     res_data;
    logic [TAG_W-1:0]  res_tag;
    logic              res_beat;
    logic              res_last;
    logic              illegal_mode;

    always #5 clk = ~clk;

    etc_sched #(.W(W), .JOB_DEPTH(4), .RES_DEPTH(4), .TAG_W(TAG_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_mode     (job_mode),
        .job_tag      (job_tag),
        .job_a        (job_a),
        .job_b        (job_b),
        .etc_op       (etc_op),
        .etc_in_a     (etc_in_a),
        .etc_in_b     (etc_in_b),
        .etc_out      (etc_out),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .res_tag      (res_tag),
        .res_beat     (res_beat),
        .res_last     (res_last),
        .illegal_mode (illegal_mode)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [RW-1:0]    data;
        logic [TAG_W-1:0] tag;
        logic             beat;
        logic             last;
    } exp_t;
    exp_t sb[$];

    task automatic chk(input string name, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // Stand-in etc arithmetic: op0 plain 4x4 product, op2 product in rows 0-1 with
    // junk in rows 2-3, op3 product inverted on its second cycle.
    function automatic logic [RW-1:0] etc_fn(input logic [3:0] op, input logic [DW-1:0] a,
                                             input logic [DW-1:0] b, input logic ph);
        logic [RW-1:0]  r;
        logic [2*W-1:0] acc;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                acc = '0;
                for (int k = 0; k < 4; k++)
                    acc = acc + (2*W)'(a[(i*4+k)*W +: W]) * (2*W)'(b[(k*4+j)*W +: W]);
                r[(i*4+j)*2*W +: 2*W] = acc;
            end
        end
        if (op == 4'd2)
            for (int e = 8; e < 16; e++) r[e*2*W +: 2*W] = (2*W)'(32'h5A0000 + e);
        if (op == 4'd3 && ph) r = ~r;
        return r;
    endfunction

    logic [RW-1:0] etc_s1 = '0;
    logic          op3_ph = 1'b0;
    always @(posedge clk) begin
        etc_s1  <= etc_fn(etc_op, etc_in_a, etc_in_b, op3_ph);
        etc_out <= etc_s1;
        op3_ph  <= (etc_op == 4'd3) ? ~op3_ph : 1'b0;
    end

    int busy_cnt = 0;
    int ill_cnt  = 0;
    int res_cnt  = 0;
    logic              stall_prev = 1'b0;
    logic [RW-1:0]     prev_data;
    logic [TAG_W+1:0]  prev_meta;

    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (etc_op !== 4'd1) busy_cnt++;
            if (illegal_mode === 1'b1) ill_cnt++;
            if (stall_prev) begin
                chk("hold_valid", res_valid, 1'b1);
                chk("hold_data", res_data, prev_data);
                chk("hold_meta", {res_tag, res_beat, res_last}, prev_meta);
            end
            if (res_valid === 1'b1 && res_ready === 1'b1) begin
                res_cnt++;
                chk("sb_has_entry", sb.size() != 0, 1'b1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("sb_data", res_data, e.data);
                    chk("sb_tag", res_tag, e.tag);
                    chk("sb_beat", res_beat, e.beat);
                    chk("sb_last", res_last, e.last);
                end
            end
            stall_prev = (res_valid === 1'b1) && (res_ready === 1'b0);
            prev_data  = res_data;
            prev_meta  = {res_tag, res_beat, res_last};
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send_job(input logic [1:0] mode, input logic [TAG_W-1:0] tag,
                            input logic [DW-1:0] a, input logic [DW-1:0] b);
        bit   ok = 1'b0;
        exp_t e;
        job_valid = 1'b1; job_mode = mode; job_tag = tag; job_a = a; job_b = b;
        for (int n = 0; n < 100 && !ok; n++) begin
            @(negedge clk);
            ok = (job_ready === 1'b1);
            @(posedge clk); #1;
        end
        job_valid = 1'b0;
        chk("job_accept", ok, 1'b1);
        e.tag = tag;
        case (mode)
            2'd0: begin e.data = etc_fn(4'd0, a, b, 1'b0); e.beat = 0; e.last = 1; sb.push_back(e); end
            2'd1: begin
                e.data = etc_fn(4'd2, a, b, 1'b0);
                e.data[RW-1:RW/2] = '0;
                e.beat = 0; e.last = 1; sb.push_back(e);
            end
            2'd2: begin
                e.data = etc_fn(4'd3, a, b, 1'b0); e.beat = 0; e.last = 0; sb.push_back(e);
                e.data = etc_fn(4'd3, a, b, 1'b1); e.beat = 1; e.last = 1; sb.push_back(e);
            end
            default: ;
        endcase
    endtask

    task automatic wait_op(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = (etc_op !== 4'd1);
        end
    endtask

    task automatic wait_res(output bit ok);
        ok = 1'b0;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = (res_valid === 1'b1);
        end
    endtask

    task automatic drain(input string name);
        bit ok = 1'b0;
        for (int n = 0; n < 200 && !ok; n++) begin
            @(negedge clk);
            ok = (sb.size() == 0) && (res_valid === 1'b0);
        end
        chk(name, ok, 1'b1);
        @(posedge clk); #1;
    endtask

    function automatic logic [DW-1:0] rand_mat();
        logic [DW-1:0] m;
        for (int e = 0; e < 16; e++) m[e*W +: W] = W'($urandom_range(0, 255));
        return m;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [DW-1:0] a, b, hold_a, hold_b;
        logic [RW-1:0] all3, gold;
        bit ok;

        // Reset values
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_etc_op", etc_op, 4'd1);
        chk("rst_in_a", etc_in_a, '0);
        chk("rst_in_b", etc_in_b, '0);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_illegal", illegal_mode, 1'b0);
        chk("rst_job_ready", job_ready, 1'b1);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk); chk("quiet0_op", etc_op, 4'd1);
        @(negedge clk); chk("quiet1_op", etc_op, 4'd1);
        @(posedge clk); #1;

        // 1: MODE_W identity x all-3
        res_ready = 1'b1;
        a = '0;
        for (int i = 0; i < 4; i++) a[(i*5)*W +: W] = W'(1);
        for (int e = 0; e < 16; e++) b[e*W +: W] = W'(3);
        for (int e = 0; e < 16; e++) all3[e*2*W +: 2*W] = (2*W)'(3);
        send_job(2'd0, 4'd5, a, b);
        wait_op(ok);
        chk("t1_op_seen", ok, 1'b1);
        chk("t1_op", etc_op, 4'd0);
        @(negedge clk); chk("t1_op_idle", etc_op, 4'd1);
        wait_res(ok);
        chk("t1_res_seen", ok, 1'b1);
        chk("t1_data", res_data, all3);
        chk("t1_tag", res_tag, 4'd5);
        chk("t1_beat", res_beat, 1'b0);
        chk("t1_last", res_last, 1'b1);
        drain("t1_drain");

        // 2: MODE_2W_B two-cycle issue, two beats
        a = rand_mat(); b = rand_mat();
        send_job(2'd2, 4'd2, a, b);
        wait_op(ok);
        chk("t2_op_seen", ok, 1'b1);
        chk("t2_op_c0", etc_op, 4'd3);
        hold_a = etc_in_a; hold_b = etc_in_b;
        chk("t2_in_a", etc_in_a, a);
        @(negedge clk);
        chk("t2_op_c1", etc_op, 4'd3);
        chk("t2_hold_a", etc_in_a, hold_a);
        chk("t2_hold_b", etc_in_b, hold_b);
        @(negedge clk); chk("t2_op_idle", etc_op, 4'd1);
        wait_res(ok);
        chk("t2_res_seen", ok, 1'b1);
        chk("t2_b0_beat", res_beat, 1'b0);
        chk("t2_b0_last", res_last, 1'b0);
        chk("t2_b0_tag", res_tag, 4'd2);
        @(negedge clk);
        chk("t2_b1_valid", res_valid, 1'b1);
        chk("t2_b1_beat", res_beat, 1'b1);
        chk("t2_b1_last", res_last, 1'b1);
        chk("t2_b1_tag", res_tag, 4'd2);
        drain("t2_drain");

        // 3: MODE_2W_A rows 2-3 forced to zero
        a = rand_mat(); b = rand_mat();
        for (int e = 8; e < 16; e++) a[e*W +: W] = W'(e + 1);
        gold = etc_fn(4'd2, a, b, 1'b0);
        send_job(2'd1, 4'd7, a, b);
        wait_res(ok);
        chk("t3_res_seen", ok, 1'b1);
        chk("t3_rows23_zero", res_data[RW-1:RW/2], '0);
        chk("t3_rows01", res_data[RW/2-1:0], gold[RW/2-1:0]);
        drain("t3_drain");

        // 4: credit limit with the consumer stalled
        res_ready = 1'b0;
        busy_cnt = 0;
        for (int j = 0; j < 8; j++) send_job(2'd0, TAG_W'(j), rand_mat(), rand_mat());
        @(negedge clk); chk("t4_job_full", job_ready, 1'b0);
        repeat (10) @(negedge clk);
        chk("t4_issued", busy_cnt, 4);
        chk("t4_op_idle", etc_op, 4'd1);
        chk("t4_res_valid", res_valid, 1'b1);
        @(posedge clk); #1 res_ready = 1'b1;
        drain("t4_drain");
        chk("t4_job_ready", job_ready, 1'b1);

        // 5: illegal job between two legal ones
        res_cnt = 0; ill_cnt = 0;
        send_job(2'd0, 4'd1, rand_mat(), rand_mat());
        send_job(2'd3, 4'd9, rand_mat(), rand_mat());
        send_job(2'd0, 4'd3, rand_mat(), rand_mat());
        drain("t5_drain");
        chk("t5_illegal_pulses", ill_cnt, 1);
        chk("t5_results", res_cnt, 2);
        res_ready = 1'b0;
        busy_cnt = 0;
        for (int j = 0; j < 5; j++) send_job(2'd0, TAG_W'(j + 8), rand_mat(), rand_mat());
        repeat (10) @(negedge clk);
        chk("t5_credits_full", busy_cnt, 4);
        @(posedge clk); #1 res_ready = 1'b1;
        drain("t5_drain2");

        // 6: reset while in OP3_HI
        send_job(2'd2, 4'd4, rand_mat(), rand_mat());
        wait_op(ok);
        chk("t6_op_seen", ok, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_rst_op", etc_op, 4'd1);
        chk("t6_rst_in_a", etc_in_a, '0);
        chk("t6_rst_res_valid", res_valid, 1'b0);
        chk("t6_rst_illegal", illegal_mode, 1'b0);
        sb.delete();
        @(posedge clk); #1 rst_n = 1'b1;
        a = rand_mat(); b = rand_mat();
        send_job(2'd0, 4'd6, a, b);
        @(negedge clk); chk("t6_quiet0", etc_op, 4'd1);
        @(negedge clk); chk("t6_quiet1", etc_op, 4'd1);
        @(negedge clk); chk("t6_issue", etc_op, 4'd0);
        wait_res(ok);
        chk("t6_res_seen", ok, 1'b1);
        chk("t6_tag", res_tag, 4'd6);
        drain("t6_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
